// File: rtl/mem_stage_nway_pkg.sv
// Shared definitions for the MEM stage: access size codes, FSM states, CP0 exception codes
// and the store strobe/replication/alignment helpers.
package mem_stage_nway_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DONE,
    ST_DRAIN
  } mem_state_t;

  function automatic logic [3:0] mem_wstrb(input logic [1:0] size, input logic [1:0] a);
    case (size)
      MEM_SIZE_BYTE: return 4'b0001 << a;
      MEM_SIZE_HALF: return 4'b0011 << a;
      default:       return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across byte lanes so the strobes alone pick the target bytes.
  function automatic logic [31:0] mem_wdata_rep(input logic [1:0] size, input logic [31:0] w);
    case (size)
      MEM_SIZE_BYTE: return {4{w[7:0]}};
      MEM_SIZE_HALF: return {2{w[15:0]}};
      default:       return w;
    endcase
  endfunction

  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == MEM_SIZE_HALF) && a[0]) || ((size == MEM_SIZE_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the returned word by the byte offset and zero/sign extends
// according to access size.
module mem_load_align
  import mem_stage_nway_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      MEM_SIZE_BYTE: result = {{24{sign & shifted[7]}}, shifted[7:0]};
      MEM_SIZE_HALF: result = {{16{sign & shifted[15]}}, shifted[15:0]};
      default:       result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_nway.sv
// N-lane MEM stage: stage register, split-handshake data port FSM, load alignment and WB-stall buffering.
// Optional macro MEM_ALIGN_EXC_EN adds misaligned-access detection with exc_valid/exc_code/exc_badvaddr.
module mem_stage_nway
  import mem_stage_nway_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wb_stall,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*PC_W-1:0]   in_pc,
  input  logic [LANES-1:0]        in_rf_we,
  input  logic [LANES*5-1:0]      in_rf_waddr,
  input  logic [LANES*DATA_W-1:0] in_rf_wdata,
  input  logic                    in_mem_en,
  input  logic                    in_mem_we,
  input  logic [1:0]              in_mem_size,
  input  logic                    in_mem_sign,
  input  logic [31:0]             in_mem_addr,
  input  logic [31:0]             in_mem_wdata,
  output logic                    data_req,
  output logic                    data_wr,
  output logic [1:0]              data_size,
  output logic [31:0]             data_addr,
  output logic [3:0]              data_wstrb,
  output logic [31:0]             data_wdata,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  input  logic [31:0]             data_rdata,
  output logic                    stallreq,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*PC_W-1:0]   out_pc,
  output logic [LANES-1:0]        out_rf_we,
  output logic [LANES*5-1:0]      out_rf_waddr,
  output logic [LANES*DATA_W-1:0] out_rf_wdata
`ifdef MEM_ALIGN_EXC_EN
  ,
  output logic                    exc_valid,
  output logic [4:0]              exc_code,
  output logic [31:0]             exc_badvaddr
`endif
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_stage_nway: DATA_W must be 32");
  end

  mem_state_t              state;
  logic [LANES-1:0]        st_valid;
  logic [LANES-1:0]        st_rf_we;
  logic [LANES*PC_W-1:0]   st_pc;
  logic [LANES*5-1:0]      st_rf_waddr;
  logic [LANES*DATA_W-1:0] st_rf_wdata;
  logic                    st_mem_en;
  logic                    st_mem_we;
  logic                    st_mem_sign;
  logic [1:0]              st_mem_size;
  logic [31:0]             st_mem_addr;
  logic [31:0]             st_mem_wdata;
  logic [31:0]             rbuf;
  logic [31:0]             load_res;
  logic                    advance;
  logic                    start_req;
  logic                    out_ok;
  logic                    lane0_mis;

`ifdef MEM_ALIGN_EXC_EN
  assign lane0_mis = st_mem_en & mem_misaligned(st_mem_size, st_mem_addr[1:0]);
  assign start_req = in_valid[0] & in_mem_en & ~flush
                   & ~mem_misaligned(in_mem_size, in_mem_addr[1:0]);
  assign exc_valid    = st_valid[0] & lane0_mis & ~flush;
  assign exc_code     = st_mem_we ? EXC_ADES : EXC_ADEL;
  assign exc_badvaddr = st_mem_addr;
`else
  assign lane0_mis = 1'b0;
  assign start_req = in_valid[0] & in_mem_en & ~flush;
`endif

  assign stallreq = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_HOLD) || (state == ST_DRAIN);
  assign advance  = ~stallreq & ~wb_stall;
  // All lanes retire together: the stage is only visible to WB when no memory access is in flight.
  assign out_ok   = (state == ST_IDLE) || (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      st_valid     <= '0;
      st_rf_we     <= '0;
      st_pc        <= '0;
      st_rf_waddr  <= '0;
      st_rf_wdata  <= '0;
      st_mem_en    <= 1'b0;
      st_mem_we    <= 1'b0;
      st_mem_sign  <= 1'b0;
      st_mem_size  <= MEM_SIZE_BYTE;
      st_mem_addr  <= '0;
      st_mem_wdata <= '0;
      rbuf         <= '0;
    end else begin
      if (advance) begin
        st_valid     <= flush ? '0 : in_valid;
        st_rf_we     <= in_rf_we;
        st_pc        <= in_pc;
        st_rf_waddr  <= in_rf_waddr;
        st_rf_wdata  <= in_rf_wdata;
        st_mem_en    <= in_mem_en;
        st_mem_we    <= in_mem_we;
        st_mem_sign  <= in_mem_sign;
        st_mem_size  <= in_mem_size;
        st_mem_addr  <= in_mem_addr;
        st_mem_wdata <= in_mem_wdata;
      end else if (flush) begin
        st_valid <= '0;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (advance)    state <= start_req ? ST_REQ : ST_IDLE;
          else if (flush) state <= ST_IDLE;
        end
        ST_REQ: begin
          if (data_addr_ok && data_data_ok) begin
            rbuf  <= data_rdata;
            state <= flush ? ST_IDLE : (wb_stall ? ST_HOLD : ST_DONE);
          end else if (data_addr_ok) begin
            state <= flush ? ST_DRAIN : ST_WAIT;
          end else if (flush) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            rbuf  <= data_rdata;
            state <= flush ? ST_IDLE : (wb_stall ? ST_HOLD : ST_DONE);
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (flush)          state <= ST_IDLE;
          else if (!wb_stall) state <= ST_DONE;
        end
        ST_DRAIN: begin
          if (data_data_ok) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_req   = (state == ST_REQ);
  assign data_wr    = st_mem_we;
  assign data_size  = st_mem_size;
  assign data_addr  = st_mem_addr;
  assign data_wstrb = st_mem_we ? mem_wstrb(st_mem_size, st_mem_addr[1:0]) : 4'b0000;
  assign data_wdata = mem_wdata_rep(st_mem_size, st_mem_wdata);

  mem_load_align u_load_align (
    .rdata   (rbuf),
    .addr_lo (st_mem_addr[1:0]),
    .size    (st_mem_size),
    .sign    (st_mem_sign),
    .result  (load_res)
  );

  always_comb begin
    out_valid    = (flush || !out_ok) ? '0 : st_valid;
    out_pc       = st_pc;
    out_rf_waddr = st_rf_waddr;
    out_rf_we    = st_rf_we;
    out_rf_wdata = st_rf_wdata;
    if (lane0_mis) out_rf_we[0] = 1'b0;
    if (st_mem_en && !st_mem_we) out_rf_wdata[DATA_W-1:0] = load_res;
  end

endmodule

// File: tb/tb_mem_stage_nway.sv
// Self-checking bench for mem_stage_nway: directed memory scenarios plus randomized loads/stores
// and non-memory traffic checked against a transaction-level reference model.
module tb_mem_stage_nway;

  logic        clk = 1'b0;
  logic        rst, flush, wb_stall;
  logic [1:0]  in_valid, in_rf_we;
  logic [63:0] in_pc, in_rf_wdata;
  logic [9:0]  in_rf_waddr;
  logic        in_mem_en, in_mem_we, in_mem_sign;
  logic [1:0]  in_mem_size;
  logic [31:0] in_mem_addr, in_mem_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok, stallreq;
  logic [1:0]  out_valid, out_rf_we;
  logic [63:0] out_pc, out_rf_wdata;
  logic [9:0]  out_rf_waddr;
`ifdef MEM_ALIGN_EXC_EN
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_res, last_wd;
  logic [3:0]  last_strb;
  int          last_stalls;

  always #5 clk = ~clk;

  mem_stage_nway #(.LANES(2), .PC_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb_stall(wb_stall),
    .in_valid(in_valid), .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_rf_wdata(in_rf_wdata), .in_mem_en(in_mem_en), .in_mem_we(in_mem_we),
    .in_mem_size(in_mem_size), .in_mem_sign(in_mem_sign), .in_mem_addr(in_mem_addr),
    .in_mem_wdata(in_mem_wdata), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .stallreq(stallreq), .out_valid(out_valid), .out_pc(out_pc), .out_rf_we(out_rf_we),
    .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata)
`ifdef MEM_ALIGN_EXC_EN
    , .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_load(input logic [31:0] addr);
    @(negedge clk);
    in_valid = 2'b01; in_rf_we = 2'b01; in_rf_waddr = 10'd3; in_pc = 64'h0;
    in_mem_en = 1'b1; in_mem_we = 1'b0; in_mem_size = 2'd2; in_mem_sign = 1'b0;
    in_mem_addr = addr; in_mem_wdata = 32'h0;
    @(negedge clk);
    in_valid = 2'b00; in_mem_en = 1'b0;
  endtask

  // Full memory transaction with a responder: addr_ok after aok_d REQ cycles, data_ok dok_d
  // cycles after acceptance, wb_stall held for 'hold' cycles starting at the data_ok cycle.
  task automatic mem_op(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int aok_d, input int dok_d, input int hold);
    int nb, c, dok_c, stalls;
    bit accepted, done, v1;
    logic [31:0] mask, exp_res, exp_wd, pc0, pc1, d0, d1;
    logic [3:0]  exp_strb;
    logic [4:0]  wa1;
    nb = 1 << size;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    exp_res = (nb == 4) ? rdata : ((rdata >> (8 * addr[1:0])) & mask);
    if (sign && nb < 4 && exp_res[8 * nb - 1]) exp_res = exp_res | ~mask;
    exp_strb = 4'(((1 << nb) - 1) << addr[1:0]);
    for (int i = 0; i < 4; i++) exp_wd[8 * i +: 8] = wdata[8 * (i % nb) +: 8];
    pc0 = $urandom; pc1 = $urandom; d0 = $urandom; d1 = $urandom;
    v1 = ($urandom_range(0, 1) == 1);
    wa1 = 5'($urandom_range(1, 31));

    @(negedge clk);
    in_valid = {v1, 1'b1}; in_pc = {pc1, pc0}; in_rf_we = {1'b1, !we};
    in_rf_waddr = {wa1, 5'd2}; in_rf_wdata = {d1, d0};
    in_mem_en = 1'b1; in_mem_we = we; in_mem_size = size; in_mem_sign = sign;
    in_mem_addr = addr; in_mem_wdata = wdata;
    @(negedge clk);
    in_valid = 2'b00; in_mem_en = 1'b0;

    accepted = 0; done = 0; stalls = 0; dok_c = 1000; c = 0;
    while (!done && c < 60) begin
      if (stallreq) stalls++;
      if (out_valid != 2'b00) begin
        done = 1;
        chk("done_valid", 64'(out_valid), 64'({v1, 1'b1}));
        chk("done_lane0", 64'(out_rf_wdata[31:0]), 64'(we ? d0 : exp_res));
        chk("done_lane1", 64'(out_rf_wdata[63:32]), 64'(d1));
        chk("done_pc", out_pc, {pc1, pc0});
        chk("done_we", 64'(out_rf_we), 64'({1'b1, !we}));
        chk("done_waddr", 64'(out_rf_waddr), 64'({wa1, 5'd2}));
        chk("done_req", 64'(data_req), 64'd0);
        last_res = out_rf_wdata[31:0];
      end else if (!accepted) begin
        chk("req_valid", 64'(data_req), 64'd1);
        chk("req_addr", 64'(data_addr), 64'(addr));
        chk("req_wr", 64'(data_wr), 64'(we));
        chk("req_size", 64'(data_size), 64'(size));
        if (we) begin
          chk("req_wstrb", 64'(data_wstrb), 64'(exp_strb));
          chk("req_wdata", 64'(data_wdata), 64'(exp_wd));
          last_strb = data_wstrb;
          last_wd = data_wdata;
        end
      end else if (c > dok_c && !we) begin
        chk("hold_data", 64'(out_rf_wdata[31:0]), 64'(exp_res));
      end
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      if (!done) begin
        if (!accepted && c == aok_d) begin
          data_addr_ok = 1'b1; accepted = 1; dok_c = c + dok_d;
        end
        if (accepted && c == dok_c) begin
          data_data_ok = 1'b1; data_rdata = rdata;
        end
        wb_stall = (c >= dok_c) && (c < dok_c + hold);
        @(negedge clk);
        c++;
      end
    end
    if (!done) chk("timeout", 64'd0, 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(aok_d + 1 + dok_d + hold));
    last_stalls = stalls;
    wb_stall = 1'b0;
    @(negedge clk);
    chk("after_valid", 64'(out_valid), 64'd0);
    chk("after_stall", 64'(stallreq), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  m_v, m_we, sz;
    logic [63:0] m_pc, m_wd;
    logic [9:0]  m_wa;
    logic [31:0] a;

    rst = 1'b1; flush = 1'b0; wb_stall = 1'b0;
    in_valid = '0; in_pc = '0; in_rf_we = '0; in_rf_waddr = '0; in_rf_wdata = '0;
    in_mem_en = 1'b0; in_mem_we = 1'b0; in_mem_size = 2'd0; in_mem_sign = 1'b0;
    in_mem_addr = '0; in_mem_wdata = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_req", 64'(data_req), 64'd0);
    chk("rst_stall", 64'(stallreq), 64'd0);
    rst = 1'b0;

    // Directed loads/stores
    mem_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0);
    chk("lw_res", 64'(last_res), 64'hDEADBEEF);
    chk("lw_stalls", 64'(last_stalls), 64'd3);
    mem_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 1, 1, 0);
    chk("lb_res", 64'(last_res), 64'hFFFFFF80);
    mem_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, 0, 0);
    chk("lbu_res", 64'(last_res), 64'h00000080);
    mem_op(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h80123456, 0, 1, 0);
    chk("lh_res", 64'(last_res), 64'hFFFF8012);
    mem_op(1'b1, 2'd0, 1'b0, 32'h201, 32'h12, 32'h0, 0, 1, 0);
    chk("sb_strb", 64'(last_strb), 64'b0010);
    chk("sb_wdata", 64'(last_wd), 64'h12121212);
    mem_op(1'b1, 2'd1, 1'b0, 32'h2, 32'hABCD, 32'h0, 2, 0, 0);
    chk("sh_strb", 64'(last_strb), 64'b1100);
    mem_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 1, 4);
    chk("hold_res", 64'(last_res), 64'hCAFEF00D);
    chk("hold_stalls", 64'(last_stalls), 64'd6);

    // Flush in WAIT: pending data_ok swallowed, nothing retires
    issue_load(32'h100);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    chk("fw_valid", 64'(out_valid), 64'd0);
    chk("fw_stall", 64'(stallreq), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    chk("drain_stall0", 64'(stallreq), 64'd1);
    @(negedge clk);
    chk("drain_stall1", 64'(stallreq), 64'd1);
    data_data_ok = 1'b1; data_rdata = 32'h11223344;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("drain_idle", 64'(stallreq), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_req", 64'(data_req), 64'd0);

    // Flush in REQ before acceptance drops the request
    issue_load(32'h300);
    flush = 1'b1;
    #1;
    chk("fr_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("fr_req", 64'(data_req), 64'd0);
    chk("fr_stall", 64'(stallreq), 64'd0);

    // Non-memory bundle: flush gates out_valid and kills a stalled stage
    @(negedge clk);
    in_valid = 2'b11; in_mem_en = 1'b0;
    @(negedge clk);
    in_valid = 2'b00;
    chk("nm_valid", 64'(out_valid), 64'd3);
    wb_stall = 1'b1; flush = 1'b1;
    #1;
    chk("nm_flush_gate", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("nm_flush_kill", 64'(out_valid), 64'd0);
    wb_stall = 1'b0;

    // Randomized memory transactions
    for (int i = 0; i < 14; i++) begin
      sz = 2'($urandom_range(0, 2));
      a = $urandom;
      a = a & ~(32'((1 << sz) - 1));
      mem_op(($urandom_range(0, 1) == 1), sz, ($urandom_range(0, 1) == 1), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Randomized non-memory traffic through a one-register pipeline model
    m_v = '0; m_we = '0; m_pc = '0; m_wd = '0; m_wa = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rnd_valid", 64'(out_valid), 64'(m_v));
        chk("rnd_pc", out_pc, m_pc);
        chk("rnd_wdata", out_rf_wdata, m_wd);
        chk("rnd_waddr", 64'(out_rf_waddr), 64'(m_wa));
        chk("rnd_we", 64'(out_rf_we), 64'(m_we));
      end
      in_valid = 2'($urandom_range(0, 3)); in_rf_we = 2'($urandom_range(0, 3));
      in_pc = {$urandom, $urandom}; in_rf_wdata = {$urandom, $urandom};
      in_rf_waddr = 10'($urandom_range(0, 1023)); in_mem_en = 1'b0;
      wb_stall = ($urandom_range(0, 3) == 0);
      if (!wb_stall) begin
        m_v = in_valid; m_we = in_rf_we; m_pc = in_pc; m_wd = in_rf_wdata; m_wa = in_rf_waddr;
      end
    end
    @(negedge clk);
    wb_stall = 1'b0; in_valid = 2'b00;

`ifdef MEM_ALIGN_EXC_EN
    @(negedge clk);
    in_valid = 2'b01; in_rf_we = 2'b01; in_mem_en = 1'b1; in_mem_we = 1'b0;
    in_mem_size = 2'd2; in_mem_addr = 32'h102;
    @(negedge clk);
    in_valid = 2'b00; in_mem_en = 1'b0;
    chk("exc_req", 64'(data_req), 64'd0);
    chk("exc_valid", 64'(exc_valid), 64'd1);
    chk("exc_code", 64'(exc_code), 64'h04);
    chk("exc_badvaddr", 64'(exc_badvaddr), 64'h102);
    chk("exc_rf_we", 64'(out_rf_we[0]), 64'd0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
